// File: rtl/cache_dre_flush.sv
// ============================================================================
//  Module   : cache_dre_flush
//  Purpose  : Write-back engine for one cache line. Walks the line a word-pair
//             at a time, writes back every word with valid bytes, then clears
//             that pair's byte-valid mask in the DRE store.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_dre_flush #(
    parameter int ADDR_WIDTH      = 8,
    parameter int LINE_WORDS_LOG2 = 3,
    parameter int MEM_ADDR_WIDTH  = 30
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic                                  start,
    input  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0] start_line,
    input  logic [1:0]                            start_channel,
    input  logic [MEM_ADDR_WIDTH-1:0]             start_memBase,
    output logic                                  busy,
    output logic                                  done,

    output logic                                  ri_sel,
    output logic [ADDR_WIDTH:0]                   ri_readAddress,
    output logic [1:0]                            ri_readChannel,
    input  logic [7:0]                            ri_readData,
    output logic [ADDR_WIDTH-1:0]                 ri_writeAddress,
    output logic [1:0]                            ri_writeChannel,
    output logic                                  ri_writeEnable,
    output logic [7:0]                            ri_writeData,

    output logic [ADDR_WIDTH-1:0]                 data_readAddress,
    output logic [1:0]                            data_readChannel,
    input  logic [31:0]                           data_readData,

    output logic                                  mem_req,
    output logic [MEM_ADDR_WIDTH-1:0]             mem_addr,
    output logic [3:0]                            mem_byteEnable,
    output logic [31:0]                           mem_writeData,
    input  logic                                  mem_ack
);

    localparam int c_LINE_W = ADDR_WIDTH - LINE_WORDS_LOG2;
    localparam logic [LINE_WORDS_LOG2-1:0] c_LAST_PAIR =
        LINE_WORDS_LOG2'((1 << LINE_WORDS_LOG2) - 2);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_DRE     = 3'd1,
        ST_LATCH      = 3'd2,
        ST_RD_DATA    = 3'd3,
        ST_LATCH_DATA = 3'd4,
        ST_MEM_REQ    = 3'd5,
        ST_CLR        = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

    state_t                      r_state;
    logic [c_LINE_W-1:0]         r_line;
    logic [1:0]                  r_channel;
    logic [MEM_ADDR_WIDTH-1:0]   r_memBase;
    // Word offset of the even word of the current pair; bit 0 is always 0.
    logic [LINE_WORDS_LOG2-1:0]  r_pair;
    logic                        r_word;
    logic [7:0]                  r_mask;

    logic [LINE_WORDS_LOG2-1:0]  w_oddWord;
    logic [LINE_WORDS_LOG2-1:0]  w_nextPair;
    logic [LINE_WORDS_LOG2-1:0]  w_wordOff;

    assign w_oddWord  = r_pair | LINE_WORDS_LOG2'(1);
    assign w_nextPair = r_pair + LINE_WORDS_LOG2'(2);
    assign w_wordOff  = r_pair | LINE_WORDS_LOG2'(r_word);

    assign ri_sel           = busy;
    assign ri_readChannel   = r_channel;
    assign ri_writeChannel  = r_channel;
    assign data_readChannel = r_channel;
    assign ri_writeData     = 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_line           <= '0;
            r_channel        <= '0;
            r_memBase        <= '0;
            r_pair           <= '0;
            r_word           <= 1'b0;
            r_mask           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            ri_readAddress   <= '0;
            ri_writeAddress  <= '0;
            ri_writeEnable   <= 1'b0;
            data_readAddress <= '0;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            mem_byteEnable   <= '0;
            mem_writeData    <= '0;
        end else begin
            done           <= 1'b0;
            ri_writeEnable <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_line         <= start_line;
                        r_channel      <= start_channel;
                        r_memBase      <= start_memBase;
                        r_pair         <= '0;
                        r_word         <= 1'b0;
                        busy           <= 1'b1;
                        ri_readAddress <= {start_line, {LINE_WORDS_LOG2{1'b0}}, 1'b0};
                        r_state        <= ST_RD_DRE;
                    end
                end

                ST_RD_DRE: r_state <= ST_LATCH;

                // The skip decision is taken on the raw RAM output so that an
                // empty pair costs no extra cycle before its clear.
                ST_LATCH: begin
                    r_mask <= ri_readData;
                    if (ri_readData[3:0] != 4'h0) begin
                        r_word           <= 1'b0;
                        data_readAddress <= {r_line, r_pair};
                        r_state          <= ST_RD_DATA;
                    end else if (ri_readData[7:4] != 4'h0) begin
                        r_word           <= 1'b1;
                        data_readAddress <= {r_line, w_oddWord};
                        r_state          <= ST_RD_DATA;
                    end else begin
                        r_word          <= 1'b0;
                        ri_writeEnable  <= 1'b1;
                        ri_writeAddress <= {r_line, r_pair};
                        r_state         <= ST_CLR;
                    end
                end

                ST_RD_DATA: r_state <= ST_LATCH_DATA;

                ST_LATCH_DATA: begin
                    mem_req        <= 1'b1;
                    mem_addr       <= r_memBase + MEM_ADDR_WIDTH'(w_wordOff);
                    mem_byteEnable <= r_word ? r_mask[7:4] : r_mask[3:0];
                    mem_writeData  <= data_readData;
                    r_state        <= ST_MEM_REQ;
                end

                ST_MEM_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!r_word && (r_mask[7:4] != 4'h0)) begin
                            r_word           <= 1'b1;
                            data_readAddress <= {r_line, w_oddWord};
                            r_state          <= ST_RD_DATA;
                        end else begin
                            ri_writeEnable  <= 1'b1;
                            ri_writeAddress <= {r_line, r_pair};
                            r_state         <= ST_CLR;
                        end
                    end
                end

                ST_CLR: begin
                    if (r_pair == c_LAST_PAIR) begin
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_pair         <= w_nextPair;
                        r_word         <= 1'b0;
                        ri_readAddress <= {r_line, w_nextPair, 1'b0};
                        r_state        <= ST_RD_DRE;
                    end
                end

                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_dre_flush.sv
// ============================================================================
//  Module   : tb_cache_dre_flush
//  Purpose  : Directed self-checking bench for cache_dre_flush with RAM and
//             memory-port models.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_dre_flush;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  start_line = '0;
    logic [1:0]  start_channel = '0;
    logic [29:0] start_memBase = '0;
    logic        busy, done, ri_sel;
    logic [8:0]  ri_readAddress;
    logic [1:0]  ri_readChannel;
    logic [7:0]  ri_readData = '0;
    logic [7:0]  ri_writeAddress;
    logic [1:0]  ri_writeChannel;
    logic        ri_writeEnable;
    logic [7:0]  ri_writeData;
    logic [7:0]  data_readAddress;
    logic [1:0]  data_readChannel;
    logic [31:0] data_readData = '0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [3:0]  mem_byteEnable;
    logic [31:0] mem_writeData;
    logic        mem_ack = 1'b0;

    cache_dre_flush #(
        .ADDR_WIDTH(8), .LINE_WORDS_LOG2(3), .MEM_ADDR_WIDTH(30)
    ) dut (
        .clk(clk), .rst(rst),
        .start(start), .start_line(start_line), .start_channel(start_channel),
        .start_memBase(start_memBase), .busy(busy), .done(done),
        .ri_sel(ri_sel), .ri_readAddress(ri_readAddress),
        .ri_readChannel(ri_readChannel), .ri_readData(ri_readData),
        .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
        .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData),
        .data_readAddress(data_readAddress), .data_readChannel(data_readChannel),
        .data_readData(data_readData),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteEnable(mem_byteEnable),
        .mem_writeData(mem_writeData), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } memTxn_t;

    logic [7:0]  dre     [0:1023];
    logic [31:0] dataMem [0:1023];

    int          passCnt = 0;
    int          totalCnt = 0;
    int          busyCnt, doneCnt, stabErr, reqCycles, reqCnt;
    int          ackDelay = 0;
    logic        spuriousAck = 1'b0;
    logic [7:0]  clrQ [$];
    logic [1:0]  clrChQ [$];
    memTxn_t     memQ [$];
    logic        prevReq = 1'b0, prevAck = 1'b0;
    logic [29:0] prevAddr;
    logic [3:0]  prevBe;
    logic [31:0] prevData;

    // Synchronous-read RAMs: data appears the cycle after the address.
    always @(posedge clk) begin
        ri_readData   <= dre[{ri_readChannel, ri_readAddress[8:1]}];
        data_readData <= dataMem[{data_readChannel, data_readAddress}];
    end

    // Memory-port responder and activity monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        busyCnt += int'(busy);
        doneCnt += int'(done);
        if (ri_writeEnable) begin
            clrQ.push_back(ri_writeAddress);
            clrChQ.push_back(ri_writeChannel);
        end
        if (mem_req) begin
            reqCycles++;
            if (prevReq && !prevAck &&
                (mem_addr !== prevAddr || mem_byteEnable !== prevBe || mem_writeData !== prevData))
                stabErr++;
            mem_ack = (reqCnt == ackDelay);
            reqCnt++;
            if (mem_ack) memQ.push_back('{mem_addr, mem_byteEnable, mem_writeData});
        end else begin
            mem_ack = spuriousAck;
            reqCnt  = 0;
        end
        prevReq  = mem_req;
        prevAck  = mem_ack;
        prevAddr = mem_addr;
        prevBe   = mem_byteEnable;
        prevData = mem_writeData;
    end

    task automatic runFlush(input logic [4:0] line, input logic [1:0] ch,
                            input logic [29:0] base, input int pulseAt,
                            output bit timedOut);
        busyCnt = 0; doneCnt = 0; stabErr = 0; reqCycles = 0;
        clrQ.delete(); clrChQ.delete(); memQ.delete();
        start_line = line; start_channel = ch; start_memBase = base; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        timedOut = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (doneCnt > 0) begin
                timedOut = 1'b0;
                break;
            end
            if (i == pulseAt) begin
                start = 1'b1; start_line = 5'd7; start_channel = 2'd3; start_memBase = 30'h999;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passCnt++;
        totalCnt++; if (ri_sel !== 1'b0) $display("FAIL reset_ri_sel got=%b exp=0", ri_sel); else passCnt++;
        totalCnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else passCnt++;
        totalCnt++; if (ri_writeEnable !== 1'b0) $display("FAIL reset_ri_we got=%b exp=0", ri_writeEnable); else passCnt++;
        totalCnt++; if ({mem_addr, mem_byteEnable, mem_writeData} !== 66'd0)
            $display("FAIL reset_mem_outputs got=%h/%h/%h exp=0", mem_addr, mem_byteEnable, mem_writeData); else passCnt++;
        totalCnt++; if ({ri_readAddress, ri_writeAddress, data_readAddress, ri_readChannel} !== 27'd0)
            $display("FAIL reset_addresses got=%h/%h/%h/%h exp=0", ri_readAddress, ri_writeAddress,
                     data_readAddress, ri_readChannel); else passCnt++;
        totalCnt++; if (ri_writeData !== 8'h00) $display("FAIL reset_ri_wdata got=%h exp=00", ri_writeData); else passCnt++;
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_zero_line;
        bit to;
        logic [7:0] expAddr [4] = '{8'd24, 8'd26, 8'd28, 8'd30};
        runFlush(5'd3, 2'd1, 30'h0, -1, to);
        totalCnt++; if (to) $display("FAIL zero_timeout no done pulse"); else passCnt++;
        totalCnt++; if (busyCnt != 13) $display("FAIL zero_busy_cycles got=%0d exp=13", busyCnt); else passCnt++;
        totalCnt++; if (doneCnt != 1) $display("FAIL zero_done_pulses got=%0d exp=1", doneCnt); else passCnt++;
        totalCnt++; if (reqCycles != 0) $display("FAIL zero_mem_req got=%0d exp=0", reqCycles); else passCnt++;
        totalCnt++; if (clrQ.size() != 4) $display("FAIL zero_clr_count got=%0d exp=4", clrQ.size()); else passCnt++;
        for (int i = 0; i < 4 && i < clrQ.size(); i++) begin
            totalCnt++;
            if (clrQ[i] !== expAddr[i] || clrChQ[i] !== 2'd1)
                $display("FAIL zero_clr_addr[%0d] got=%0d ch=%0d exp=%0d ch=1", i, clrQ[i], clrChQ[i], expAddr[i]);
            else passCnt++;
        end
    endtask

    task automatic test_single_word(input int delay);
        bit to;
        int expBusy = 16 + delay;
        ackDelay = delay;
        spuriousAck = (delay != 0);
        runFlush(5'd2, 2'd0, 30'h100, -1, to);
        spuriousAck = 1'b0;
        totalCnt++; if (to) $display("FAIL single_timeout delay=%0d", delay); else passCnt++;
        totalCnt++; if (busyCnt != expBusy) $display("FAIL single_busy got=%0d exp=%0d", busyCnt, expBusy); else passCnt++;
        totalCnt++; if (reqCycles != delay + 1) $display("FAIL single_req_cycles got=%0d exp=%0d", reqCycles, delay + 1); else passCnt++;
        totalCnt++; if (stabErr != 0) $display("FAIL single_hold_stable changes=%0d exp=0", stabErr); else passCnt++;
        totalCnt++; if (memQ.size() != 1) $display("FAIL single_txn_count got=%0d exp=1", memQ.size());
        else if (memQ[0].addr !== 30'h105 || memQ[0].be !== 4'b0101 || memQ[0].data !== 32'hDEADBEEF)
            $display("FAIL single_txn got=%h/%b/%h exp=105/0101/deadbeef", memQ[0].addr, memQ[0].be, memQ[0].data);
        else passCnt++;
        totalCnt++; if (clrQ.size() != 4 || clrQ[2] !== 8'd20)
            $display("FAIL single_clr count=%0d exp=4 (pair addr 20 third)", clrQ.size()); else passCnt++;
        ackDelay = 0;
    endtask

    task automatic test_full_line;
        bit to;
        runFlush(5'd4, 2'd2, 30'h3FFF_FFFC, -1, to);
        totalCnt++; if (to) $display("FAIL full_timeout"); else passCnt++;
        totalCnt++; if (busyCnt != 37) $display("FAIL full_busy got=%0d exp=37", busyCnt); else passCnt++;
        totalCnt++; if (memQ.size() != 8) $display("FAIL full_txn_count got=%0d exp=8", memQ.size()); else passCnt++;
        for (int i = 0; i < 8 && i < memQ.size(); i++) begin
            logic [29:0] ea;
            ea = 30'h3FFF_FFFC + 30'(i);
            totalCnt++;
            if (memQ[i].addr !== ea || memQ[i].be !== 4'hF || memQ[i].data !== (32'hA000_0000 + 32'(i)))
                $display("FAIL full_txn[%0d] got=%h/%h/%h exp=%h/f/%h", i, memQ[i].addr, memQ[i].be,
                         memQ[i].data, ea, 32'hA000_0000 + 32'(i));
            else passCnt++;
        end
        totalCnt++; if (clrQ.size() != 4 || clrQ[3] !== 8'd38 || clrChQ[3] !== 2'd2)
            $display("FAIL full_clr count=%0d exp=4 last=38 ch=2", clrQ.size()); else passCnt++;
    endtask

    task automatic test_start_while_busy;
        bit to;
        runFlush(5'd1, 2'd0, 30'h40, 4, to);
        totalCnt++; if (to) $display("FAIL busy_start_timeout"); else passCnt++;
        totalCnt++; if (busyCnt != 16) $display("FAIL busy_start_cycles got=%0d exp=16", busyCnt); else passCnt++;
        totalCnt++; if (memQ.size() != 1) $display("FAIL busy_start_txn_count got=%0d exp=1", memQ.size());
        else if (memQ[0].addr !== 30'h42 || memQ[0].be !== 4'hF || memQ[0].data !== 32'h12345678)
            $display("FAIL busy_start_txn got=%h/%h/%h exp=42/f/12345678", memQ[0].addr, memQ[0].be, memQ[0].data);
        else passCnt++;
        totalCnt++; if (clrQ.size() != 4 || clrQ[0] !== 8'd8 || clrQ[3] !== 8'd14)
            $display("FAIL busy_start_clr count=%0d exp=4 first=8 last=14", clrQ.size()); else passCnt++;
        totalCnt++; if (busy !== 1'b0 || doneCnt != 1)
            $display("FAIL busy_start_no_restart busy=%b done=%0d exp=0/1", busy, doneCnt); else passCnt++;
    endtask

    task automatic test_reset_mid_flush;
        bit to;
        bit seen = 1'b0;
        busyCnt = 0; doneCnt = 0; stabErr = 0; reqCycles = 0;
        clrQ.delete(); clrChQ.delete(); memQ.delete();
        ackDelay = 0;
        start_line = 5'd0; start_channel = 2'd0; start_memBase = 30'h200; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (memQ.size() == 1) ackDelay = 99;
            if (mem_req && memQ.size() == 1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        totalCnt++; if (!seen) $display("FAIL rst_mid_second_req_not_reached"); else passCnt++;
        rst = 1'b1;
        @(negedge clk); #1;
        totalCnt++; if (mem_req !== 1'b0) $display("FAIL rst_mid_mem_req got=%b exp=0", mem_req); else passCnt++;
        totalCnt++; if (busy !== 1'b0 || ri_sel !== 1'b0) $display("FAIL rst_mid_busy got=%b/%b exp=0", busy, ri_sel); else passCnt++;
        totalCnt++; if (clrQ.size() != 0) $display("FAIL rst_mid_clr got=%0d exp=0", clrQ.size()); else passCnt++;
        rst = 1'b0;
        ackDelay = 0;
        @(negedge clk); #1;
        totalCnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_idle busy=%b done=%b exp=0", busy, done); else passCnt++;
        runFlush(5'd0, 2'd0, 30'h200, -1, to);
        totalCnt++; if (to) $display("FAIL reflush_timeout"); else passCnt++;
        totalCnt++; if (memQ.size() != 2) $display("FAIL reflush_txn_count got=%0d exp=2", memQ.size());
        else if (memQ[0].addr !== 30'h200 || memQ[1].addr !== 30'h201 ||
                 memQ[0].data !== 32'hC0DE_0000 || memQ[1].data !== 32'hC0DE_0001)
            $display("FAIL reflush_txn got=%h:%h %h:%h exp=200:c0de0000 201:c0de0001",
                     memQ[0].addr, memQ[0].data, memQ[1].addr, memQ[1].data);
        else passCnt++;
        totalCnt++; if (clrQ.size() != 4 || clrQ[0] !== 8'd0) $display("FAIL reflush_clr count=%0d exp=4", clrQ.size()); else passCnt++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dre[i] = 8'h00;
            dataMem[i] = 32'h0;
        end
        // ch0 line2: word 5 (odd word of pair at 20) has bytes 0 and 2 valid
        dre[{2'd0, 8'd20}] = 8'h50;
        dataMem[{2'd0, 8'd21}] = 32'hDEADBEEF;
        // ch2 line4: every byte valid
        for (int p = 0; p < 4; p++) dre[{2'd2, 8'(32 + 2 * p)}] = 8'hFF;
        for (int w = 0; w < 8; w++) dataMem[{2'd2, 8'(32 + w)}] = 32'hA000_0000 + 32'(w);
        // ch0 line1: word 2 fully valid
        dre[{2'd0, 8'd10}] = 8'h0F;
        dataMem[{2'd0, 8'd10}] = 32'h12345678;
        // ch3 line7 would be the bogus restart target; give it data to expose a restart
        dre[{2'd3, 8'd56}] = 8'hFF;
        // ch0 line0: both words of pair 0 valid
        dre[{2'd0, 8'd0}] = 8'hFF;
        dataMem[{2'd0, 8'd0}] = 32'hC0DE_0000;
        dataMem[{2'd0, 8'd1}] = 32'hC0DE_0001;

        test_reset;
        test_zero_line;
        test_single_word(0);
        test_single_word(3);
        test_full_line;
        test_start_while_busy;
        test_reset_mid_flush;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

`default_nettype wire
